rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 15 +
 rtl/rf_wb_arbiter_sync.sv | 52 +++++
 rtl/rf_wb_arbiter.sv | 101 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// The FIFO entry struct is the {rd, data} pair queued from the multi-cycle unit.
package rf_wb_arbiter_pkg;
   localparam int REG_ADDR_W       = 5;
   localparam int XLEN             = 32;
   localparam int FIFO_DEPTH_DEF   = 2;
   localparam int STARVE_LIMIT_DEF = 8;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } mc_entry_t;

   localparam int MC_ENTRY_W = $bits(mc_entry_t);
endpackage

// File: rtl/rf_wb_arbiter_sync.sv
// Synchronous FIFO with full/empty flags; pointers carry one extra wrap bit.
// Push while full and pop while empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      mem_d    = mem_q;
      if (do_push) mem_d[wr_ptr_q[AW-1:0]] = din_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the pipeline WB stage (never stalls)
// and queued multi-cycle results; tracks pending rds and starvation to stall ID.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wb_we_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   input  logic [XLEN-1:0]       wb_dat_i,
   input  logic                  mc_valid_i,
   input  logic [REG_ADDR_W-1:0] mc_rd_i,
   input  logic [XLEN-1:0]       mc_dat_i,
   output logic                  mc_ready_o,
   input  logic                  mc_issue_i,
   input  logic [REG_ADDR_W-1:0] mc_issue_rd_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   output logic                  rf_we_o,
   output logic [REG_ADDR_W-1:0] rd_o,
   output logic [XLEN-1:0]       rf_wd_o,
   output logic                  stall_o
);
   localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   mc_entry_t       in_entry, head;
   logic            fifo_full, fifo_empty;
   logic            wb_act, push, pop, head_live;
   logic [31:0]     pending_q, pending_d;
   logic [CNT_W-1:0] starve_q, starve_d;

   assign in_entry = '{rd: mc_rd_i, data: mc_dat_i};

   sync_fifo #(
      .WIDTH (MC_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .din_i   (in_entry),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Reset blanks the write port so queued results are dropped, never committed.
   assign wb_act     = !rst_i && wb_we_i && (wb_rd_i != '0);
   assign mc_ready_o = !rst_i && !fifo_full;
   assign push       = mc_valid_i && mc_ready_o;
   assign pop        = !rst_i && !wb_act && !fifo_empty;
   assign head_live  = pop && (head.rd != '0);

   always_comb begin
      rf_we_o = 1'b0;
      rd_o    = '0;
      rf_wd_o = '0;
      if (wb_act) begin
         rf_we_o = 1'b1;
         rd_o    = wb_rd_i;
         rf_wd_o = wb_dat_i;
      end else if (head_live) begin
         rf_we_o = 1'b1;
         rd_o    = head.rd;
         rf_wd_o = head.data;
      end
   end

   // Clear before set so an issue to the rd committing this cycle stays pending.
   always_comb begin
      pending_d = pending_q;
      if (head_live) pending_d[head.rd] = 1'b0;
      if (mc_issue_i && (mc_issue_rd_i != '0)) pending_d[mc_issue_rd_i] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || pop)          starve_d = '0;
      else if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
   end

   assign stall_o = pending_q[id_rs1_i] | pending_q[id_rs2_i] | pending_q[id_rd_i] |
                    (starve_q == STARVE_MAX);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_q <= '0;
         starve_q  <= '0;
      end else begin
         pending_q <= pending_d;
         starve_q  <= starve_d;
      end
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: queue-based reference model checked every cycle,
// plus literal expectations at the scenario checkpoints.
module tb_rf_wb_arbiter;
   localparam int DEPTH = 2;
   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        wb_we_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_dat_i;
   logic        mc_valid_i;
   logic [4:0]  mc_rd_i;
   logic [31:0] mc_dat_i;
   logic        mc_ready_o;
   logic        mc_issue_i;
   logic [4:0]  mc_issue_rd_i;
   logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
   logic        rf_we_o;
   logic [4:0]  rd_o;
   logic [31:0] rf_wd_o;
   logic        stall_o;

   rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_dat_i(wb_dat_i),
      .mc_valid_i(mc_valid_i), .mc_rd_i(mc_rd_i), .mc_dat_i(mc_dat_i),
      .mc_ready_o(mc_ready_o),
      .mc_issue_i(mc_issue_i), .mc_issue_rd_i(mc_issue_rd_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
      .rf_we_o(rf_we_o), .rd_o(rd_o), .rf_wd_o(rf_wd_o), .stall_o(stall_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of results, pending set, wait-cycle count.
   typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
   ent_t        mq[$];
   logic [31:0] pend = '0;
   int          starve = 0;

   function automatic void model_eval(output logic commit, output logic ready,
                                      output logic we, output logic [4:0] rd,
                                      output logic [31:0] wd, output logic stall);
      logic wb_uses;
      wb_uses = !rst_i && wb_we_i && (wb_rd_i != 0);
      commit  = !rst_i && !wb_uses && (mq.size() > 0);
      ready   = !rst_i && (mq.size() < DEPTH);
      we = 1'b0; rd = '0; wd = '0;
      if (wb_uses) begin
         we = 1'b1; rd = wb_rd_i; wd = wb_dat_i;
      end else if (commit && mq[0].rd != 0) begin
         we = 1'b1; rd = mq[0].rd; wd = mq[0].data;
      end
      stall = pend[id_rs1_i] || pend[id_rs2_i] || pend[id_rd_i] || (starve >= LIMIT);
   endfunction

   always @(posedge clk) begin : model_update
      logic c, r, w, s;
      logic [4:0] a;
      logic [31:0] d;
      ent_t h;
      bit was_empty;
      model_eval(c, r, w, a, d, s);
      if (rst_i) begin
         mq.delete();
         pend   = '0;
         starve = 0;
      end else begin
         was_empty = (mq.size() == 0);
         if (c) begin
            h = mq.pop_front();
            if (h.rd != 0) pend[h.rd] = 1'b0;
         end
         if (mc_valid_i && r) mq.push_back('{mc_rd_i, mc_dat_i});
         if (mc_issue_i && mc_issue_rd_i != 0) pend[mc_issue_rd_i] = 1'b1;
         if (was_empty || c)    starve = 0;
         else if (starve < LIMIT) starve = starve + 1;
      end
   end

   always @(negedge clk) begin : compare
      logic c, r, w, s;
      logic [4:0] a;
      logic [31:0] d;
      if (chk_en) begin
         model_eval(c, r, w, a, d, s);
         chk("m_ready", mc_ready_o, r);
         chk("m_we",    rf_we_o,    w);
         chk("m_rd",    rd_o,       a);
         chk("m_wd",    rf_wd_o,    d);
         chk("m_stall", stall_o,    s);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg;
      @(negedge clk);
   endtask

   initial begin
      rst_i = 1'b1; wb_we_i = 0; wb_rd_i = 0; wb_dat_i = 0;
      mc_valid_i = 0; mc_rd_i = 0; mc_dat_i = 0; mc_issue_i = 0; mc_issue_rd_i = 0;
      id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
      tick;
      chk_en = 1'b1;
      tick;
      rst_i = 1'b0;

      // reset state
      at_neg;
      chk("rst_ready", mc_ready_o, 1); chk("rst_we", rf_we_o, 0);
      chk("rst_rd", rd_o, 0); chk("rst_wd", rf_wd_o, 0); chk("rst_stall", stall_o, 0);
      tick;

      // single mc result rd=5
      mc_issue_i = 1; mc_issue_rd_i = 5;
      tick;
      mc_issue_i = 0; mc_issue_rd_i = 0;
      mc_valid_i = 1; mc_rd_i = 5; mc_dat_i = 32'hDEADBEEF; id_rs1_i = 5;
      at_neg; chk("r31_stall_pre", stall_o, 1); chk("r31_we_pre", rf_we_o, 0);
      tick;
      mc_valid_i = 0;
      at_neg; chk("r31_we", rf_we_o, 1); chk("r31_rd", rd_o, 5);
      chk("r31_wd", rf_wd_o, 32'hDEADBEEF); chk("r31_stall_commit", stall_o, 1);
      tick;
      at_neg; chk("r31_stall_post", stall_o, 0); chk("r31_we_post", rf_we_o, 0);
      id_rs1_i = 0;
      tick;

      // WB busy every cycle while mc pushes three results
      for (int i = 0; i < 3; i++) begin
         wb_we_i = 1; wb_rd_i = 3; wb_dat_i = 32'h1000 + i;
         mc_valid_i = 1; mc_rd_i = 5'(10 + i); mc_dat_i = 32'hA0 + i;
         at_neg;
         chk("r32_we", rf_we_o, 1); chk("r32_rd", rd_o, 3); chk("r32_wd", rf_wd_o, 32'h1000 + i);
         chk("r32_ready", mc_ready_o, (i == 2) ? 0 : 1);
         tick;
      end
      mc_valid_i = 0; wb_we_i = 0; wb_rd_i = 0; wb_dat_i = 0;
      at_neg; chk("r32_drain0_rd", rd_o, 10); chk("r32_drain0_wd", rf_wd_o, 32'hA0);
      tick;
      at_neg; chk("r32_drain1_rd", rd_o, 11); chk("r32_drain1_wd", rf_wd_o, 32'hA1);
      tick;
      at_neg; chk("r32_idle_we", rf_we_o, 0);
      tick;

      // RAW hazard on rd 7
      mc_issue_i = 1; mc_issue_rd_i = 7;
      tick;
      mc_issue_i = 0; mc_issue_rd_i = 0; id_rs1_i = 7; id_rs2_i = 0;
      for (int i = 0; i < 3; i++) begin
         at_neg; chk("r33_stall_wait", stall_o, 1);
         tick;
      end
      mc_valid_i = 1; mc_rd_i = 7; mc_dat_i = 32'h77;
      tick;
      mc_valid_i = 0;
      at_neg; chk("r33_we", rf_we_o, 1); chk("r33_rd", rd_o, 7); chk("r33_stall_commit", stall_o, 1);
      tick;
      at_neg; chk("r33_stall_clear", stall_o, 0);
      id_rs1_i = 0;
      mc_issue_i = 1; mc_issue_rd_i = 0;
      tick;
      mc_issue_i = 0; id_rs2_i = 0;
      at_neg; chk("r33_x0_nostall", stall_o, 0);
      tick;

      // starvation with WB busy
      wb_we_i = 1; wb_rd_i = 3; wb_dat_i = 32'h3333;
      mc_valid_i = 1; mc_rd_i = 9; mc_dat_i = 32'h99;
      tick;
      mc_valid_i = 0;
      for (int k = 1; k <= 12; k++) begin
         at_neg; chk("r34_stall", stall_o, (k >= 9) ? 1 : 0);
         tick;
      end
      wb_we_i = 0; wb_rd_i = 0; wb_dat_i = 0;
      at_neg; chk("r34_commit_we", rf_we_o, 1); chk("r34_commit_rd", rd_o, 9);
      chk("r34_stall_commit", stall_o, 1);
      tick;
      at_neg; chk("r34_stall_drop", stall_o, 0);
      tick;

      // reset with two queued entries and pending bits
      wb_we_i = 1; wb_rd_i = 3; wb_dat_i = 32'h4444;
      mc_issue_i = 1; mc_issue_rd_i = 10; mc_valid_i = 1; mc_rd_i = 10; mc_dat_i = 32'hB0;
      tick;
      mc_issue_rd_i = 11; mc_rd_i = 11; mc_dat_i = 32'hB1;
      tick;
      mc_issue_i = 0; mc_issue_rd_i = 0; mc_valid_i = 0;
      wb_we_i = 0; wb_rd_i = 0; wb_dat_i = 0; id_rs1_i = 10; rst_i = 1;
      at_neg; chk("r35_we_in_rst", rf_we_o, 0);
      tick;
      rst_i = 0;
      at_neg;
      chk("r35_ready", mc_ready_o, 1); chk("r35_we", rf_we_o, 0); chk("r35_rd", rd_o, 0);
      chk("r35_wd", rf_wd_o, 0); chk("r35_stall", stall_o, 0);
      tick;
      at_neg; chk("r35_we_after", rf_we_o, 0);
      id_rs1_i = 0;
      tick;

      // x0 traffic from both sources
      wb_we_i = 1; wb_rd_i = 3; wb_dat_i = 32'h5555;
      mc_valid_i = 1; mc_rd_i = 0; mc_dat_i = 32'h66;
      tick;
      mc_dat_i = 32'h67;
      tick;
      mc_valid_i = 0; wb_we_i = 1; wb_rd_i = 0; wb_dat_i = 32'h55;
      at_neg; chk("r36_full", mc_ready_o, 0); chk("r36_we0", rf_we_o, 0); chk("r36_rd0", rd_o, 0);
      tick;
      wb_we_i = 0; wb_dat_i = 0;
      at_neg; chk("r36_ready1", mc_ready_o, 1); chk("r36_we1", rf_we_o, 0);
      tick;
      at_neg; chk("r36_we2", rf_we_o, 0); chk("r36_ready2", mc_ready_o, 1);
      tick;

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
endmodule
